// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl_if
// Description : Request/response handshake bundle between the ID/EX control
//               and the alu issue front end.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32
);
    // Request channel
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_aluop;
    logic [5:0]        in_funct;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;

    // Response channel
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic              out_cout;
    logic              out_overflow;
    logic              out_illegal;

    // Requester / response consumer side
    modport master (
        output in_valid, in_aluop, in_funct, in_src1, in_src2, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_cout,
               out_overflow, out_illegal
    );

    // Issue controller side
    modport slave (
        input  in_valid, in_aluop, in_funct, in_src1, in_src2, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_cout,
               out_overflow, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Accepts an ALU operation request, decodes ALUOp/funct into the
//               alu's 4-bit control, drives registered operands, captures the
//               alu result/flags and returns them over a valid/ready channel.
//               Keeps a saturating count of completed overflowing ops.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  wire                clk,
    input  wire                rst_n,
    alu_issue_ctrl_if.slave    bus,
    output logic               alu_rst_n,
    output logic [DATA_W-1:0]  alu_src1,
    output logic [DATA_W-1:0]  alu_src2,
    output logic [3:0]         alu_control,
    output logic [2:0]         alu_bonus_control,
    input  wire  [DATA_W-1:0]  alu_result,
    input  wire                alu_zero,
    input  wire                alu_cout,
    input  wire                alu_overflow,
    output logic [CNT_W-1:0]   ovf_count
);

    localparam logic [3:0] C_CTRL_AND = 4'b0000;
    localparam logic [3:0] C_CTRL_OR  = 4'b0001;
    localparam logic [3:0] C_CTRL_ADD = 4'b0010;
    localparam logic [3:0] C_CTRL_SUB = 4'b0110;
    localparam logic [3:0] C_CTRL_SLT = 4'b0111;
    localparam logic [3:0] C_CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_alu_rst_n;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [3:0]        r_ctrl;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_zero;
    logic              r_out_cout;
    logic              r_out_ovf;
    logic              r_out_illegal;
    logic [CNT_W-1:0]  r_ovf_count;

    logic [3:0]        w_ctrl;
    logic              w_legal;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_resp_hs;
    logic              w_addsub;
    logic              w_cout_m;
    logic              w_ovf_m;

    // r_alu_rst_n doubles as "out of reset for at least one clock", gating in_ready
    assign w_in_ready = (r_state == S_IDLE) && r_alu_rst_n;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_resp_hs  = r_out_valid && bus.out_ready;

    // Carry/overflow are only meaningful for the adder ops; mask them otherwise
    assign w_addsub = (r_ctrl == C_CTRL_ADD) || (r_ctrl == C_CTRL_SUB);
    assign w_cout_m = w_addsub && alu_cout;
    assign w_ovf_m  = w_addsub && alu_overflow;

    // Decode ALUOp/funct into alu control; anything unrecognised is illegal
    always_comb begin
        w_ctrl  = C_CTRL_ADD;
        w_legal = 1'b1;
        case (bus.in_aluop)
            2'b00: w_ctrl = C_CTRL_ADD;
            2'b01: w_ctrl = C_CTRL_SUB;
            2'b10: begin
                case (bus.in_funct)
                    6'b100000: w_ctrl = C_CTRL_ADD;
                    6'b100010: w_ctrl = C_CTRL_SUB;
                    6'b100100: w_ctrl = C_CTRL_AND;
                    6'b100101: w_ctrl = C_CTRL_OR;
                    6'b101010: w_ctrl = C_CTRL_SLT;
                    6'b100111: w_ctrl = C_CTRL_NOR;
                    default:   w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: illegal requests skip EXEC since there is nothing to compute
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_legal ? S_EXEC : S_DONE;
            S_EXEC: w_next = S_DONE;
            S_DONE: if (w_resp_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand/control registers feeding the alu; only legal requests load them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_rst_n <= 1'b0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_ctrl      <= C_CTRL_ADD;
        end else begin
            r_alu_rst_n <= 1'b1;
            if (w_accept && w_legal) begin
                r_src1 <= bus.in_src1;
                r_src2 <= bus.in_src2;
                r_ctrl <= w_ctrl;
            end
        end
    end

    // Response capture: illegal result on accept, alu result at the EXEC edge;
    // out_valid rises one clock after entering DONE and drops on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_zero    <= 1'b0;
            r_out_cout    <= 1'b0;
            r_out_ovf     <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            r_out_valid <= (r_state == S_DONE) && !w_resp_hs;
            if (w_accept && !w_legal) begin
                r_out_result  <= '0;
                r_out_zero    <= 1'b0;
                r_out_cout    <= 1'b0;
                r_out_ovf     <= 1'b0;
                r_out_illegal <= 1'b1;
            end else if (r_state == S_EXEC) begin
                r_out_result  <= alu_result;
                r_out_zero    <= alu_zero;
                r_out_cout    <= w_cout_m;
                r_out_ovf     <= w_ovf_m;
                r_out_illegal <= 1'b0;
            end
        end
    end

    // Saturating overflow event counter, bumped at the EXEC capture edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if ((r_state == S_EXEC) && w_ovf_m && (r_ovf_count != {CNT_W{1'b1}})) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_result    = r_out_result;
    assign bus.out_zero      = r_out_zero;
    assign bus.out_cout      = r_out_cout;
    assign bus.out_overflow  = r_out_ovf;
    assign bus.out_illegal   = r_out_illegal;
    assign alu_rst_n         = r_alu_rst_n;
    assign alu_src1          = r_src1;
    assign alu_src2          = r_src2;
    assign alu_control       = r_ctrl;
    assign alu_bonus_control = 3'b000;
    assign ovf_count         = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with a behavioural
//               alu stub, directed boundary cases and randomized requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int DW      = 32;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_W(DW)) bus ();

    logic          alu_rst_n;
    logic [DW-1:0] alu_src1, alu_src2, alu_result;
    logic [3:0]    alu_control;
    logic [2:0]    alu_bonus_control;
    logic          alu_zero, alu_cout, alu_overflow;
    logic [CW-1:0] ovf_count;

    alu_issue_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .alu_rst_n         (alu_rst_n),
        .alu_src1          (alu_src1),
        .alu_src2          (alu_src2),
        .alu_control       (alu_control),
        .alu_bonus_control (alu_bonus_control),
        .alu_result        (alu_result),
        .alu_zero          (alu_zero),
        .alu_cout          (alu_cout),
        .alu_overflow      (alu_overflow),
        .ovf_count         (ovf_count)
    );

    // Bit-level alu stub: invert controls, and/or/add/slt selected by op[1:0]
    logic [DW-1:0] t_a, t_b;
    logic [DW:0]   t_s;
    always_comb begin
        t_a = alu_control[3] ? ~alu_src1 : alu_src1;
        t_b = alu_control[2] ? ~alu_src2 : alu_src2;
        t_s = {1'b0, t_a} + {1'b0, t_b} + {{DW{1'b0}}, alu_control[2]};
        alu_cout     = t_s[DW];
        alu_overflow = (t_a[DW-1] == t_b[DW-1]) && (t_s[DW-1] != t_a[DW-1]);
        case (alu_control[1:0])
            2'b00:   alu_result = t_a & t_b;
            2'b01:   alu_result = t_a | t_b;
            2'b10:   alu_result = t_s[DW-1:0];
            default: alu_result = {{(DW-1){1'b0}}, t_s[DW-1] ^ alu_overflow};
        endcase
        alu_zero = (alu_result == '0);
    end

    int n_checks = 0;
    int n_err    = 0;

    // Model state: last legal operands/control and the overflow counter
    logic [DW-1:0] m_src1, m_src2;
    logic [3:0]    m_ctrl;
    int            m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: what the whole front end + alu should return for a request
    function automatic void ref_model(input logic [1:0] op, input logic [5:0] fn,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic z,
                                      output logic c, output logic v,
                                      output logic ill, output logic [3:0] code);
        longint sa, sb, ua, ub, full;
        int kind;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
        res = 0; z = 0; c = 0; v = 0; ill = 0; code = 4'b0010; kind = -1;
        if (op == 2'b00) kind = 0;
        else if (op == 2'b01) kind = 1;
        else if (op == 2'b10) begin
            if (fn == 6'd32) kind = 0;
            else if (fn == 6'd34) kind = 1;
            else if (fn == 6'd36) kind = 2;
            else if (fn == 6'd37) kind = 3;
            else if (fn == 6'd42) kind = 4;
            else if (fn == 6'd39) kind = 5;
        end
        case (kind)
            0: begin
                full = sa + sb; res = full[31:0];
                c = (ua + ub) > 64'hFFFF_FFFF;
                v = full != longint'($signed(res)); code = 4'b0010;
            end
            1: begin
                full = sa - sb; res = full[31:0];
                c = (ua >= ub);
                v = full != longint'($signed(res)); code = 4'b0110;
            end
            2: begin res = a & b;                 code = 4'b0000; end
            3: begin res = a | b;                 code = 4'b0001; end
            4: begin res = (sa < sb) ? 32'd1 : 0; code = 4'b0111; end
            5: begin res = ~(a | b);              code = 4'b1100; end
            default: ill = 1;
        endcase
        z = !ill && (res == 0);
    endfunction

    // One full request/response transaction with optional response back-pressure
    task automatic do_op(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic ez, ec, ev, ei;
        logic [3:0] ecode;
        int lat;
        ref_model(op, fn, a, b, er, ez, ec, ev, ei, ecode);
        @(negedge clk);
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1; bus.in_aluop = op; bus.in_funct = fn;
        bus.in_src1 = a; bus.in_src2 = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (!ei) begin m_src1 = a; m_src2 = b; m_ctrl = ecode; end
        chk("alu_src1", 64'(alu_src1), 64'(m_src1));
        chk("alu_src2", 64'(alu_src2), 64'(m_src2));
        chk("alu_control", 64'(alu_control), 64'(m_ctrl));
        chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
        lat = 0;
        while (!bus.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), ei ? 64'd1 : 64'd2);
        if (!ei && ev && m_cnt < CNT_MAX) m_cnt++;
        chk("out_result", 64'(bus.out_result), 64'(er));
        chk("out_zero", 64'(bus.out_zero), 64'(ez));
        chk("out_cout", 64'(bus.out_cout), 64'(ec));
        chk("out_overflow", 64'(bus.out_overflow), 64'(ev));
        chk("out_illegal", 64'(bus.out_illegal), 64'(ei));
        chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
        chk("in_ready_done", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_result", 64'(bus.out_result), 64'(er));
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_hs_valid", 64'(bus.out_valid), 64'd0);
        chk("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_hs_result", 64'(bus.out_result), 64'(er));
    endtask

    logic [5:0] fn_tab [0:5];

    initial begin
        int  pick;
        logic [1:0]  r_op;
        logic [5:0]  r_fn;
        logic [31:0] r_a, r_b;

        fn_tab[0] = 6'd32; fn_tab[1] = 6'd34; fn_tab[2] = 6'd36;
        fn_tab[3] = 6'd37; fn_tab[4] = 6'd42; fn_tab[5] = 6'd39;
        m_src1 = 0; m_src2 = 0; m_ctrl = 4'b0010; m_cnt = 0;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_aluop = 2'b00; bus.in_funct = 6'd0;
        bus.in_src1 = 0; bus.in_src2 = 0; bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_alu_rst_n", 64'(alu_rst_n), 64'd0);
        chk("rst_alu_control", 64'(alu_control), 64'h2);
        chk("rst_alu_src1", 64'(alu_src1), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
        chk("rst_ovf_count", 64'(ovf_count), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_before_clk", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("alu_rst_n_released", 64'(alu_rst_n), 64'd1);
        chk("bonus_control", 64'(alu_bonus_control), 64'd0);

        // Directed cases
        do_op(2'b10, 6'd32, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        do_op(2'b01, 6'd0,  32'd5, 32'd5, 0);
        do_op(2'b10, 6'd42, 32'hFFFF_FFFD, 32'd2, 0);
        do_op(2'b10, 6'd0,  32'h1234, 32'h5678, 0);
        do_op(2'b11, 6'd32, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        do_op(2'b10, 6'd36, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5);
        do_op(2'b10, 6'd37, 32'hF0F0_F0F0, 32'hFFFF_0000, 0);
        do_op(2'b10, 6'd39, 32'h8000_0000, 32'h8000_0001, 0);
        do_op(2'b00, 6'd0,  32'h8000_0000, 32'h8000_0000, 0);
        do_op(2'b10, 6'd34, 32'h8000_0000, 32'h0000_0001, 0);
        do_op(2'b00, 6'd0,  32'h4000_0000, 32'h4000_0000, 0);
        do_op(2'b00, 6'd0,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        do_op(2'b01, 6'd0,  32'd3, 32'd7, 0);

        // Randomized requests
        for (int k = 0; k < 40; k++) begin
            pick = int'($urandom_range(0, 9));
            r_a = $urandom; r_b = $urandom;
            if ($urandom_range(0, 3) == 0) r_a = {1'b0, {31{1'b1}}};
            if ($urandom_range(0, 3) == 0) r_b = {1'b1, {31{1'b0}}};
            r_fn = 6'($urandom);
            case (pick)
                0: r_op = 2'b00;
                1: r_op = 2'b01;
                8: r_op = 2'b10;
                9: r_op = 2'b11;
                default: begin r_op = 2'b10; r_fn = fn_tab[pick - 2]; end
            endcase
            do_op(r_op, r_fn, r_a, r_b, int'($urandom_range(0, 2)));
        end

        // Reset while the op is in EXEC
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_aluop = 2'b00;
        bus.in_src1 = 32'h7FFF_FFFF; bus.in_src2 = 32'h7FFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ovf_count", 64'(ovf_count), 64'd0);
        chk("mid_rst_alu_rst_n", 64'(alu_rst_n), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("mid_rst_alu_src1", 64'(alu_src1), 64'd0);
        chk("mid_rst_out_result", 64'(bus.out_result), 64'd0);
        m_src1 = 0; m_src2 = 0; m_ctrl = 4'b0010; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        do_op(2'b10, 6'd32, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        do_op(2'b10, 6'd36, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
